seq_fsm_ctrl: RTL and testbench

SEQ_FSM_CTRL -- requirements
Module: seq_fsm_ctrl

---
 rtl/seq_fsm_ctrl.sv | 128 ++++++++++++
 tb/tb_seq_fsm_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_fsm_ctrl.sv
// Job sequencer: runs `repeat_n` passes of `run_len` cycles each,
// with pause (hold) and abort support and a one-cycle done pulse.
module seq_fsm_ctrl #(
  parameter int CNT_W = 8,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic [CNT_W-1:0] run_len,
  input  logic [REP_W-1:0] repeat_n,
  output logic             done,
  output logic             busy,
  output logic             aborted,
  output logic [2:0]       state_out,
  output logic [CNT_W-1:0] count_out,
  output logic [REP_W-1:0] pass_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    LOAD    = 3'b001,
    RUNNING = 3'b010,
    PAUSED  = 3'b011,
    FINISH  = 3'b100
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] pass_q, pass_d;
  logic             ab_q, ab_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rep_d   = rep_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    ab_d    = ab_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          len_d   = run_len;
          // zero passes is treated as a single pass
          rep_d   = (repeat_n == '0) ? REP_ONE : repeat_n;
          ab_d    = 1'b0;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        pass_d  = '0;
        state_d = (len_q == '0) ? FINISH : RUNNING;
      end
      RUNNING: begin
        if (abort) begin
          state_d = FINISH;
          ab_d    = 1'b1;
        end else if (hold) begin
          state_d = PAUSED;
        end else if (cnt_q != len_q - CNT_ONE) begin
          cnt_d = cnt_q + CNT_ONE;
        end else if (pass_q != rep_q - REP_ONE) begin
          cnt_d  = '0;
          pass_d = pass_q + REP_ONE;
        end else begin
          state_d = FINISH;
        end
      end
      PAUSED: begin
        if (abort) begin
          state_d = FINISH;
          ab_d    = 1'b1;
        end else if (!hold) begin
          state_d = RUNNING;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done_d = (state_d == FINISH);
    busy_d = (state_d == LOAD) ||
             (state_d == RUNNING) ||
             (state_d == PAUSED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      rep_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= '0;
      ab_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rep_q   <= rep_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      ab_q    <= ab_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign done      = done_q;
  assign busy      = busy_q;
  assign aborted   = ab_q;
  assign state_out = state_q;
  assign count_out = cnt_q;
  assign pass_out  = pass_q;

endmodule

// File: tb/tb_seq_fsm_ctrl.sv
// Bench for seq_fsm_ctrl: directed scenarios plus random traffic,
// checked against an elapsed-cycle reference model.
module tb_seq_fsm_ctrl;

  localparam int S_IDLE = 0;
  localparam int S_LOAD = 1;
  localparam int S_RUN  = 2;
  localparam int S_PAU  = 3;
  localparam int S_FIN  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, abort, hold;
  logic [7:0] run_len;
  logic [3:0] rep_in;
  logic       done, busy, aborted;
  logic [2:0] state_out;
  logic [7:0] count_out;
  logic [3:0] pass_out;

  int checks = 0;
  int errors = 0;

  // reference model: progress is tracked as cycles of work elapsed
  int m_st, m_len, m_rep, m_el, m_cnt, m_pass;
  bit m_ab;

  seq_fsm_ctrl #(.CNT_W(8), .REP_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .hold(hold), .run_len(run_len), .repeat_n(rep_in),
    .done(done), .busy(busy), .aborted(aborted),
    .state_out(state_out), .count_out(count_out),
    .pass_out(pass_out)
  );

  always #5 clk = ~clk;

  wire [17:0] obs = {done, busy, aborted, state_out,
                     count_out, pass_out};

  function automatic logic [17:0] exp_vec();
    logic d, b;
    d = (m_st == S_FIN);
    b = (m_st == S_LOAD) || (m_st == S_RUN) || (m_st == S_PAU);
    return {d, b, m_ab, 3'(m_st), 8'(m_cnt), 4'(m_pass)};
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_len = 0; m_rep = 1; m_el = 0;
    m_cnt = 0; m_pass = 0; m_ab = 0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    case (m_st)
      S_IDLE: if (start) begin
        m_st  = S_LOAD;
        m_len = int'(run_len);
        m_rep = (rep_in == 0) ? 1 : int'(rep_in);
        m_ab  = 0;
      end
      S_LOAD: begin
        m_el = 0; m_cnt = 0; m_pass = 0;
        m_st = (m_len == 0) ? S_FIN : S_RUN;
      end
      S_RUN: begin
        if (abort) begin m_st = S_FIN; m_ab = 1; end
        else if (hold) m_st = S_PAU;
        else if (m_el + 1 >= m_len * m_rep) m_st = S_FIN;
        else m_el++;
      end
      S_PAU: begin
        if (abort) begin m_st = S_FIN; m_ab = 1; end
        else if (!hold) m_st = S_RUN;
      end
      default: m_st = S_IDLE;
    endcase
    if (m_st == S_RUN || m_st == S_PAU) begin
      m_cnt  = m_el % m_len;
      m_pass = m_el / m_len;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit s, input bit a, input bit h,
                       input int l, input int r);
    start = s; abort = a; hold = h;
    run_len = 8'(l); rep_in = 4'(r);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    step(); step();
    if (obs !== 18'h0) begin
      errors++;
      $display("FAIL reset: got %h want %h", obs, 18'h0);
    end
    checks++;
    reset = 1'b0;
    step();
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL reset_idle: got %h want %h", obs, exp_vec());
    end
    checks++;
  endtask

  task automatic test_basic();
    int seen_run;
    seen_run = 0;
    drive(1, 0, 0, 3, 2);
    step();
    drive(0, 0, 0, 9, 9);
    for (int i = 0; i < 10; i++) begin
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL basic c%0d: got %h want %h", i, obs, exp_vec());
      end
      checks++;
      if (state_out == 3'(S_RUN)) seen_run++;
      step();
    end
    if (seen_run !== 6) begin
      errors++;
      $display("FAIL basic_runlen: got %0d want 6", seen_run);
    end
    checks++;
  endtask

  task automatic test_hold();
    int paused;
    paused = 0;
    drive(1, 0, 0, 4, 1);
    step();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL hold c%0d: got %h want %h", i, obs, exp_vec());
      end
      checks++;
      if (state_out == 3'(S_PAU)) begin
        paused++;
        if (count_out !== 8'd1) begin
          errors++;
          $display("FAIL hold_cnt: got %0d want 1", count_out);
        end
        checks++;
      end
      hold = (i >= 2 && i <= 4);
      step();
    end
    if (paused !== 3) begin
      errors++;
      $display("FAIL hold_paused: got %0d want 3", paused);
    end
    checks++;
  endtask

  task automatic test_abort();
    drive(1, 0, 0, 10, 1);
    step();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      abort = (m_st == S_RUN && m_cnt == 5);
      step();
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL abort c%0d: got %h want %h", i, obs, exp_vec());
      end
      checks++;
    end
    abort = 1'b0;
    if (aborted !== 1'b1) begin
      errors++;
      $display("FAIL abort_sticky: got %b want 1", aborted);
    end
    checks++;
    drive(1, 0, 0, 2, 1);
    step();
    if (obs !== exp_vec() || aborted !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear: got %h want %h", obs, exp_vec());
    end
    checks++;
    drive(0, 0, 0, 0, 0);
    repeat (5) step();
  endtask

  task automatic test_zero_len();
    int runs;
    runs = 0;
    drive(1, 0, 0, 0, 5);
    step();
    drive(0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL zero c%0d: got %h want %h", i, obs, exp_vec());
      end
      checks++;
      if (state_out == 3'(S_RUN)) runs++;
      step();
    end
    if (runs !== 0) begin
      errors++;
      $display("FAIL zero_run: got %0d want 0", runs);
    end
    checks++;
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 0, 2, 1);
    for (int i = 0; i < 16; i++) begin
      step();
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL b2b c%0d: got %h want %h", i, obs, exp_vec());
      end
      checks++;
    end
    drive(0, 0, 0, 0, 0);
    repeat (4) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 5),
            $urandom_range(0, 3));
      step();
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL rand c%0d: got %h want %h", i, obs, exp_vec());
      end
      checks++;
    end
    drive(0, 0, 0, 0, 0);
    repeat (30) step();
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, 6, 2);
    step();
    drive(0, 0, 0, 0, 0);
    repeat (4) step();
    #2;
    reset = 1'b1;
    #1;
    if (obs !== 18'h0) begin
      errors++;
      $display("FAIL async_rst: got %h want %h", obs, 18'h0);
    end
    checks++;
    model_reset();
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL post_rst c%0d: got %h want %h", i, obs, exp_vec());
      end
      checks++;
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_basic();
    test_hold();
    test_abort();
    test_zero_len();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
